// File: rtl/hex_processor_mc.sv
// hex_processor_mc: multi-cycle Hex core with handshaked fetch, data and syscall ports
module hex_processor_mc #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 18,
    parameter int RESET_PC = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_f_valid,
    output logic [ADDR_W-1:0] o_f_addr,
    input  logic              i_f_ready,
    input  logic [7:0]        i_f_data,
    output logic              o_d_valid,
    output logic              o_d_we,
    output logic [ADDR_W-1:0] o_d_addr,
    output logic [DATA_W-1:0] o_d_wdata,
    input  logic              i_d_ready,
    input  logic [DATA_W-1:0] i_d_rdata,
    output logic              o_svc_valid,
    output logic [DATA_W-1:0] o_svc_code,
    output logic [DATA_W-1:0] o_svc_arg,
    input  logic              i_svc_ready,
    input  logic [DATA_W-1:0] i_svc_rdata,
    output logic              o_halted,
    output logic [ADDR_W-1:0] o_pc
);
    localparam logic [3:0] OP_LDAM = 4'h0;
    localparam logic [3:0] OP_LDBM = 4'h1;
    localparam logic [3:0] OP_STAM = 4'h2;
    localparam logic [3:0] OP_LDAC = 4'h3;
    localparam logic [3:0] OP_LDBC = 4'h4;
    localparam logic [3:0] OP_LDAP = 4'h5;
    localparam logic [3:0] OP_LDAI = 4'h6;
    localparam logic [3:0] OP_LDBI = 4'h7;
    localparam logic [3:0] OP_STAI = 4'h8;
    localparam logic [3:0] OP_BR   = 4'h9;
    localparam logic [3:0] OP_BRZ  = 4'hA;
    localparam logic [3:0] OP_BRN  = 4'hB;
    localparam logic [3:0] OP_OPR  = 4'hD;
    localparam logic [3:0] OP_PFIX = 4'hE;
    localparam logic [3:0] OP_NFIX = 4'hF;
    localparam logic [3:0] OPR_BRB = 4'h0;
    localparam logic [3:0] OPR_ADD = 4'h1;
    localparam logic [3:0] OPR_SUB = 4'h2;
    localparam logic [3:0] OPR_SVC = 4'h3;
    localparam logic [DATA_W-1:0] SVC_EXIT = '0;
    localparam logic [DATA_W-1:0] SVC_READ = DATA_W'(2);

    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_SVC, S_HALT} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] areg_q, areg_d;
    logic [DATA_W-1:0] breg_q, breg_d;
    logic [DATA_W-1:0] oreg_q, oreg_d;
    logic [7:0]        ir_q, ir_d;

    logic [3:0]        opc, opr;
    logic [DATA_W-1:0] opd;
    logic [ADDR_W-1:0] pc_inc, pc_rel, mem_base, mem_addr;
    logic              is_mem, is_store, is_ldb, is_svc;

    // Operand, branch target and memory address are pure functions of the
    // latched instruction and registers, so they stay stable through MEM/SVC.
    assign opc      = ir_q[7:4];
    assign opr      = ir_q[3:0];
    assign opd      = oreg_q | DATA_W'(opr);
    assign pc_inc   = pc_q + ADDR_W'(1);
    assign pc_rel   = pc_inc + opd[ADDR_W-1:0];
    assign mem_base = (opc == OP_LDAI) ? areg_q[ADDR_W-1:0] :
                      (opc == OP_LDBI || opc == OP_STAI) ? breg_q[ADDR_W-1:0] : '0;
    assign mem_addr = mem_base + opd[ADDR_W-1:0];
    assign is_store = opc == OP_STAM || opc == OP_STAI;
    assign is_ldb   = opc == OP_LDBM || opc == OP_LDBI;
    assign is_mem   = is_store || is_ldb || opc == OP_LDAM || opc == OP_LDAI;
    assign is_svc   = opc == OP_OPR && opr == OPR_SVC;

    // State and architectural registers; reset abandons any open request.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_FETCH;
            pc_q    <= ADDR_W'(RESET_PC);
            areg_q  <= '0;
            breg_q  <= '0;
            oreg_q  <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            areg_q  <= areg_d;
            breg_q  <= breg_d;
            oreg_q  <= oreg_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state and register updates; changes happen only on completing edges.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        areg_d  = areg_q;
        breg_d  = breg_q;
        oreg_d  = oreg_q;
        ir_d    = ir_q;
        case (state_q)
            S_FETCH: begin
                if (i_f_ready) begin
                    ir_d    = i_f_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_mem) begin
                    state_d = S_MEM;
                end else if (is_svc) begin
                    state_d = S_SVC;
                end else begin
                    state_d = S_FETCH;
                    pc_d    = pc_inc;
                    oreg_d  = '0;
                    case (opc)
                        OP_PFIX: oreg_d = opd << 4;
                        OP_NFIX: oreg_d = ({DATA_W{1'b1}} << 8) | (opd << 4);
                        OP_LDAC: areg_d = opd;
                        OP_LDBC: breg_d = opd;
                        OP_LDAP: areg_d = DATA_W'(pc_rel);
                        OP_BR:   pc_d   = pc_rel;
                        OP_BRZ:  pc_d   = (areg_q == '0) ? pc_rel : pc_inc;
                        OP_BRN:  pc_d   = areg_q[DATA_W-1] ? pc_rel : pc_inc;
                        OP_OPR: begin
                            case (opr)
                                OPR_ADD: areg_d = areg_q + breg_q;
                                OPR_SUB: areg_d = areg_q - breg_q;
                                OPR_BRB: pc_d   = breg_q[ADDR_W-1:0];
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase
                end
            end
            S_MEM: begin
                if (i_d_ready) begin
                    if (!is_store && is_ldb) breg_d = i_d_rdata;
                    if (!is_store && !is_ldb) areg_d = i_d_rdata;
                    pc_d    = pc_inc;
                    oreg_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_SVC: begin
                if (areg_q == SVC_EXIT) begin
                    state_d = S_HALT;
                end else if (i_svc_ready) begin
                    if (areg_q == SVC_READ) areg_d = i_svc_rdata;
                    pc_d    = pc_inc;
                    oreg_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase
    end

    // Port outputs; valids are masked by reset so they drop as soon as it asserts.
    always_comb begin
        o_f_valid   = !i_rst && state_q == S_FETCH;
        o_d_valid   = !i_rst && state_q == S_MEM;
        o_svc_valid = !i_rst && state_q == S_SVC;
        o_halted    = !i_rst && state_q == S_HALT;
        o_f_addr    = pc_q;
        o_d_we      = o_d_valid && is_store;
        o_d_addr    = mem_addr;
        o_d_wdata   = areg_q;
        o_svc_code  = areg_q;
        o_svc_arg   = breg_q;
        o_pc        = pc_q;
    end
endmodule

// File: tb/tb_hex_processor_mc.sv
// tb_hex_processor_mc: scoreboard bench for the multi-cycle Hex core (default and small configs)
module tb_hex_processor_mc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic sel = 1'b0;
    logic f_ready = 1'b0, d_ready = 1'b0, s_ready = 1'b0;
    logic [7:0] f_data = '0;
    logic [31:0] d_rdata = '0, s_rdata = '0;

    logic fv1, dv1, dwe1, sv1, h1;
    logic [17:0] fa1, da1, pc1;
    logic [31:0] dw1, sc1, sa1;
    logic fv2, dv2, dwe2, sv2, h2;
    logic [9:0] fa2, da2, pc2;
    logic [15:0] dw2, sc2, sa2;

    hex_processor_mc u_dut (
        .i_clk(clk), .i_rst(rst | sel),
        .o_f_valid(fv1), .o_f_addr(fa1), .i_f_ready(f_ready), .i_f_data(f_data),
        .o_d_valid(dv1), .o_d_we(dwe1), .o_d_addr(da1), .o_d_wdata(dw1),
        .i_d_ready(d_ready), .i_d_rdata(d_rdata),
        .o_svc_valid(sv1), .o_svc_code(sc1), .o_svc_arg(sa1),
        .i_svc_ready(s_ready), .i_svc_rdata(s_rdata),
        .o_halted(h1), .o_pc(pc1)
    );

    hex_processor_mc #(.DATA_W(16), .ADDR_W(10), .RESET_PC('h3FE)) u_dut_small (
        .i_clk(clk), .i_rst(rst | ~sel),
        .o_f_valid(fv2), .o_f_addr(fa2), .i_f_ready(f_ready), .i_f_data(f_data),
        .o_d_valid(dv2), .o_d_we(dwe2), .o_d_addr(da2), .o_d_wdata(dw2),
        .i_d_ready(d_ready), .i_d_rdata(d_rdata[15:0]),
        .o_svc_valid(sv2), .o_svc_code(sc2), .o_svc_arg(sa2),
        .i_svc_ready(s_ready), .i_svc_rdata(s_rdata[15:0]),
        .o_halted(h2), .o_pc(pc2)
    );

    logic m_fv, m_dv, m_dwe, m_sv, m_halt;
    logic [31:0] m_fa, m_da, m_dw, m_sc, m_sa, m_pc;
    assign m_fv   = sel ? fv2 : fv1;
    assign m_dv   = sel ? dv2 : dv1;
    assign m_dwe  = sel ? dwe2 : dwe1;
    assign m_sv   = sel ? sv2 : sv1;
    assign m_halt = sel ? h2 : h1;
    assign m_fa   = sel ? {22'b0, fa2} : {14'b0, fa1};
    assign m_da   = sel ? {22'b0, da2} : {14'b0, da1};
    assign m_pc   = sel ? {22'b0, pc2} : {14'b0, pc1};
    assign m_dw   = sel ? {16'b0, dw2} : dw1;
    assign m_sc   = sel ? {16'b0, sc2} : sc1;
    assign m_sa   = sel ? {16'b0, sa2} : sa1;

    logic [7:0]  prog  [1024];
    logic [7:0]  prog2 [1024];
    logic [31:0] dmem  [256];
    int f_stall = 0, d_stall = 0, s_stall = 0;
    logic [31:0] svc_val = '0;
    int n_chk = 0, n_pass = 0;
    string tname = "init";

    typedef struct {int kind; logic [31:0] a; logic [31:0] b; logic we;} ev_t;
    ev_t q[$];

    task automatic ef(int a); q.push_back('{0, 32'(a), 32'h0, 1'b0}); endtask
    task automatic ed(int a, logic we, logic [31:0] w); q.push_back('{1, 32'(a), w, we}); endtask
    task automatic es(logic [31:0] c, logic [31:0] g); q.push_back('{2, c, g, 1'b0}); endtask
    task automatic p(int a, logic [7:0] b); if (sel) prog2[a] = b; else prog[a] = b; endtask

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s %s: got %h want %h", tname, n, act, exp);
    endtask

    task automatic got(int kind, logic [31:0] a, logic [31:0] b, logic we);
        ev_t e;
        n_chk++;
        if (q.size() == 0) begin
            $display("FAIL %s unexpected event kind=%0d a=%h b=%h we=%b", tname, kind, a, b, we);
            return;
        end
        e = q.pop_front();
        if (e.kind == kind && e.a === a && e.b === b && e.we === we) n_pass++;
        else $display("FAIL %s event: got kind=%0d a=%h b=%h we=%b want kind=%0d a=%h b=%h we=%b",
                      tname, kind, a, b, we, e.kind, e.a, e.b, e.we);
    endtask

    // Memory/host responder: answers whichever request is open, after the configured stall.
    initial begin : driver
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            f_ready = 1'b0; d_ready = 1'b0; s_ready = 1'b0;
            if (rst) cnt = 0;
            else if (m_fv) begin
                f_data = sel ? prog2[m_fa[9:0]] : prog[m_fa[9:0]];
                if (cnt >= f_stall) begin f_ready = 1'b1; cnt = 0; end else cnt++;
            end else if (m_dv) begin
                d_rdata = dmem[m_da[7:0]];
                if (cnt >= d_stall) begin
                    d_ready = 1'b1; cnt = 0;
                    if (m_dwe) dmem[m_da[7:0]] = m_dw;
                end else cnt++;
            end else if (m_sv) begin
                s_rdata = svc_val;
                if (cnt >= s_stall) begin s_ready = 1'b1; cnt = 0; end else cnt++;
            end
        end
    end

    // Monitor: pops the scoreboard on every completed request and checks data-port stability.
    logic [31:0] pa, pw;
    logic pwe, d_chg;
    int d_held;
    initial begin : monitor
        d_held = 0; d_chg = 1'b0; pa = '0; pw = '0; pwe = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                d_held = 0; d_chg = 1'b0;
            end else begin
                assert ($onehot0({m_fv, m_dv, m_sv})) else begin
                    n_chk++;
                    $display("FAIL %s onehot valids: f=%b d=%b s=%b", tname, m_fv, m_dv, m_sv);
                end
                if (m_fv && f_ready) got(0, m_fa, 32'h0, 1'b0);
                if (m_dv) begin
                    if (d_held != 0 && (pa !== m_da || pw !== m_dw || pwe !== m_dwe)) d_chg = 1'b1;
                    pa = m_da; pw = m_dw; pwe = m_dwe;
                    d_held++;
                    if (d_ready) begin
                        got(1, m_da, m_dw, m_dwe);
                        chk("d_hold_cycles", d_held, d_stall + 1);
                        chk("d_stable", {31'b0, d_chg}, 32'h0);
                        d_held = 0; d_chg = 1'b0;
                    end
                end
                if (m_sv && (s_ready || m_sc == 32'h0)) got(2, m_sc, m_sa, 1'b0);
            end
        end
    end

    task automatic begin_test(string n, logic s);
        tname = n;
        rst = 1'b1;
        sel = s;
        q.delete();
        for (int i = 0; i < 1024; i++) begin prog[i] = 8'hD3; prog2[i] = 8'hD3; end
        repeat (2) @(negedge clk);
        chk("rst_valids", {29'b0, m_fv, m_dv, m_sv}, 32'h0);
        chk("rst_halted", {31'b0, m_halt}, 32'h0);
        chk("rst_pc", m_pc, s ? 32'h3FE : 32'h0);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic finish_test(int exp_pc);
        int k;
        k = 0;
        while (q.size() != 0 && k < 400) begin @(negedge clk); k++; end
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL %s timeout: %0d events outstanding", tname, q.size());
        repeat (2) @(negedge clk);
        #3;
        chk("halted", {31'b0, m_halt}, 32'h1);
        chk("halt_pc", m_pc, 32'(exp_pc));
        chk("halt_no_fetch", {31'b0, m_fv}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = '0;

        // LDAC 5; LDBC 3; ADD; STAM 0; exit
        begin_test("add", 1'b0);
        p(0, 8'h35); p(1, 8'h43); p(2, 8'hD1); p(3, 8'h20); p(4, 8'h30); p(5, 8'hD3);
        for (int i = 0; i < 4; i++) ef(i);
        ed(0, 1'b1, 32'd8); ef(4); ef(5); es(0, 3);
        release_rst();
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("pc_after_6", m_pc, 32'd3);
        finish_test(5);

        // prefixes with fetch stalls
        begin_test("prefix", 1'b0);
        f_stall = 1;
        p(0, 8'hE1); p(1, 8'h32); p(2, 8'h40); p(3, 8'h21); p(4, 8'hFF);
        p(5, 8'h3E); p(6, 8'h80); p(7, 8'h30); p(8, 8'hD3);
        for (int i = 0; i < 4; i++) ef(i);
        ed(1, 1'b1, 32'h12);
        for (int i = 4; i < 7; i++) ef(i);
        ed(0, 1'b1, 32'hFFFF_FFFE); ef(7); ef(8); es(0, 0);
        release_rst();
        finish_test(8);
        f_stall = 0;

        // branches, LDAP, SUB, BRB
        begin_test("branch", 1'b0);
        p(0, 8'h30); p(1, 8'hA2); p(4, 8'hFF); p(5, 8'h3F); p(6, 8'hB1); p(8, 8'h31);
        p(9, 8'hA2); p(10, 8'hB3); p(11, 8'h52); p(12, 8'h22); p(13, 8'h45); p(14, 8'h37);
        p(15, 8'hD2); p(16, 8'h23); p(17, 8'hE1); p(18, 8'h44); p(19, 8'hD0); p(20, 8'h30);
        p(21, 8'hD3);
        ef(0); ef(1);
        for (int i = 4; i <= 6; i++) ef(i);
        for (int i = 8; i <= 12; i++) ef(i);
        ed(2, 1'b1, 32'd14);
        for (int i = 13; i <= 16; i++) ef(i);
        ed(3, 1'b1, 32'd2);
        for (int i = 17; i <= 21; i++) ef(i);
        es(0, 20);
        release_rst();
        finish_test(21);

        // stalled data port: stores, direct and indexed loads
        begin_test("mem_stall", 1'b0);
        d_stall = 4;
        dmem[2] = 32'h1234;
        p(0, 8'hEA); p(1, 8'h35); p(2, 8'h27); p(3, 8'h17); p(4, 8'h31); p(5, 8'h66);
        p(6, 8'h40); p(7, 8'h72); p(8, 8'h29); p(9, 8'h30); p(10, 8'hD3);
        ef(0); ef(1); ef(2); ed(7, 1'b1, 32'hA5); ef(3); ed(7, 1'b0, 32'hA5);
        ef(4); ef(5); ed(7, 1'b0, 32'h1); ef(6); ef(7); ed(2, 1'b0, 32'hA5);
        ef(8); ed(9, 1'b1, 32'hA5); ef(9); ef(10); es(0, 32'h1234);
        release_rst();
        finish_test(10);
        d_stall = 0;

        // syscalls: READ with stall, WRITE, EXIT
        begin_test("svc", 1'b0);
        s_stall = 2; svc_val = 32'h41;
        p(0, 8'h32); p(1, 8'h49); p(2, 8'hD3); p(3, 8'h24); p(4, 8'h31);
        p(5, 8'hD3); p(6, 8'h25); p(7, 8'h30); p(8, 8'hD3);
        ef(0); ef(1); ef(2); es(2, 9); ef(3); ed(4, 1'b1, 32'h41);
        ef(4); ef(5); es(1, 9); ef(6); ed(5, 1'b1, 32'h1); ef(7); ef(8); es(0, 9);
        release_rst();
        finish_test(8);
        s_stall = 0;

        // reset while a data request is open
        begin_test("rst_mid_mem", 1'b0);
        d_stall = 100;
        p(0, 8'h23); p(1, 8'hD3);
        ef(0);
        release_rst();
        begin
            int k;
            k = 0;
            while (!m_dv && k < 20) begin @(negedge clk); k++; end
        end
        chk("mem_reached", {31'b0, m_dv}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("rst_drop", {29'b0, m_fv, m_dv, m_sv}, 32'h0);
        chk("rst_drop_pc", m_pc, 32'h0);
        d_stall = 0;
        q.delete();
        ef(0); ed(3, 1'b1, 32'h0); ef(1); es(0, 0);
        repeat (2) @(negedge clk);
        release_rst();
        finish_test(1);

        // DATA_W=16, ADDR_W=10: sequential pc wrap and wrapping branch offsets
        begin_test("small_wrap", 1'b1);
        p('h3FE, 8'hFF); p('h3FF, 8'h3E); p(0, 8'h25); p(1, 8'h30); p(2, 8'hFF);
        p(3, 8'hA9); p('h3FD, 8'h98); p(6, 8'h26); p(7, 8'hD3);
        ef('h3FE); ef('h3FF); ef(0); ed(5, 1'b1, 32'hFFFE); ef(1); ef(2); ef(3);
        ef('h3FD); ef(6); ed(6, 1'b1, 32'h0); ef(7); es(0, 0);
        release_rst();
        finish_test(7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
